uart_tx_queue: RTL and testbench

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_queue_if.sv | 33 +++
 rtl/uart_fifo.sv | 75 +++++++
 rtl/uart_tx_queue.sv | 81 ++++++++
 tb/tb_uart_tx_queue.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit queue.
// FSM state encoding, default FIFO depth, busy-handshake timeout.
package uart_pkg;

    localparam int DEPTH_DEF    = 8;
    localparam int BUSY_TIMEOUT = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } tx_state_e;

endpackage

// File: rtl/uart_tx_queue_if.sv
// CPU push port, status and downstream UART handshake of the TX queue.
// master = CPU/UART side, slave = the queue itself.
interface uart_tx_queue_if
    import uart_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          wr_en_i;
    logic [7:0]    wr_data_i;
    logic          clr_i;
    logic          full_o;
    logic          empty_o;
    logic [CW-1:0] count_o;
    logic          overflow_o;
    logic          uart_busy_i;
    logic          uart_wr_o;
    logic [7:0]    uart_dat_o;

    modport master (
        output wr_en_i, wr_data_i, clr_i, uart_busy_i,
        input  full_o, empty_o, count_o, overflow_o,
        input  uart_wr_o, uart_dat_o
    );

    modport slave (
        input  wr_en_i, wr_data_i, clr_i, uart_busy_i,
        output full_o, empty_o, count_o, overflow_o,
        output uart_wr_o, uart_dat_o
    );

endinterface

// File: rtl/uart_fifo.sv
// Circular byte FIFO with sticky overflow and synchronous flush.
// A pop on the same edge frees a slot, so a push to a full FIFO is then accepted.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [7:0]             data_i,
    input  logic                   pop_i,
    input  logic                   clr_i,
    output logic [7:0]             head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          do_push, do_pop;

    assign full_o     = (cnt_q == CW'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign count_o    = cnt_q;
    assign overflow_o = ovf_q;
    assign head_o     = mem_q[rptr_q];

    always_comb begin
        do_pop  = pop_i && !empty_o && !clr_i;
        do_push = push_i && !clr_i && (!full_o || do_pop);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
        end else begin
            if (do_push) wptr_d = wptr_q + AW'(1);
            if (do_pop)  rptr_d = rptr_q + AW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
            if (push_i && !do_push) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    // Storage needs no reset: only slots below the count are ever read out.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a UART transmitter through a wr/busy handshake.
// Pops one byte per transfer and waits for busy to rise and fall (or time out).
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic           sys_clk_i,
    input  logic           rst,
    uart_tx_queue_if.slave bus
);
    localparam int TW = $clog2(BUSY_TIMEOUT);

    tx_state_e     state_q;
    logic [TW-1:0] tmo_q;
    logic          wr_q;
    logic [7:0]    dat_q;
    logic [7:0]    head;
    logic          issue;

    assign issue = (state_q == IDLE) && !bus.empty_o
                && !bus.uart_busy_i && !bus.clr_i;

    uart_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i     (sys_clk_i),
        .rst_i     (rst),
        .push_i    (bus.wr_en_i),
        .data_i    (bus.wr_data_i),
        .pop_i     (issue),
        .clr_i     (bus.clr_i),
        .head_o    (head),
        .full_o    (bus.full_o),
        .empty_o   (bus.empty_o),
        .count_o   (bus.count_o),
        .overflow_o(bus.overflow_o)
    );

    assign bus.uart_wr_o  = wr_q;
    assign bus.uart_dat_o = dat_q;

    always_ff @(posedge sys_clk_i or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            wr_q    <= 1'b0;
            dat_q   <= 8'h00;
        end else begin
            wr_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (issue) begin
                        state_q <= ISSUE;
                        wr_q    <= 1'b1;
                        dat_q   <= head;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT_BUSY;
                    tmo_q   <= '0;
                end
                WAIT_BUSY: begin
                    // A transmitter that never answers must not stall the queue.
                    if (bus.uart_busy_i) begin
                        state_q <= WAIT_DONE;
                    end else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!bus.uart_busy_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: directed scenarios plus random traffic
// against a queue-level model with a responding busy model.
module tb_uart_tx_queue;
    import uart_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_queue_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_queue #(.DEPTH(DEPTH)) dut (
        .sys_clk_i(clk),
        .rst      (rst),
        .bus      (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Downstream UART model: busy for busy_len cycles after each request.
    int   cyc_n     = 0;
    int   busy_len  = 0;
    int   busy_cnt  = 0;
    logic busy_hold = 1'b0;

    logic [7:0] sent_dat [$];
    int         sent_cyc [$];
    logic       sent_busy[$];

    assign bus.uart_busy_i = busy_hold | (busy_cnt > 0);

    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (bus.uart_wr_o === 1'b1) begin
            sent_dat.push_back(bus.uart_dat_o);
            sent_cyc.push_back(cyc_n);
            sent_busy.push_back(bus.uart_busy_i);
            busy_cnt <= busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    // Reference model: pending bytes, bytes due on the wire, sticky overflow.
    logic [7:0] mq    [$];
    logic [7:0] exp_tx[$];
    logic       m_ovf;

    task automatic model_reset();
        mq.delete();
        exp_tx.delete();
        sent_dat.delete();
        sent_cyc.delete();
        sent_busy.delete();
        m_ovf = 1'b0;
    endtask

    task automatic cyc(input logic we, input logic [7:0] d,
                       input logic c);
        logic pop;
        bus.wr_en_i   = we;
        bus.wr_data_i = d;
        bus.clr_i     = c;
        @(posedge clk);
        @(negedge clk);
        pop = (bus.uart_wr_o === 1'b1);
        if (c) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (pop && mq.size() > 0) exp_tx.push_back(mq.pop_front());
            if (we) begin
                if (mq.size() < DEPTH) mq.push_back(d);
                else m_ovf = 1'b1;
            end
        end
        bus.wr_en_i = 1'b0;
        bus.clr_i   = 1'b0;
    endtask

    task automatic drain(input int bound);
        int quiet = 0;
        int n = 0;
        while (quiet < 8 && n < bound) begin
            cyc(1'b0, 8'h00, 1'b0);
            n++;
            if (mq.size() == 0 && busy_cnt == 0 && bus.uart_wr_o === 1'b0)
                quiet++;
            else
                quiet = 0;
        end
        checks++;
        if (quiet < 8) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d after %0d cycles",
                     mq.size(), n);
        end
    endtask

    task automatic check_log(input string tag);
        checks++;
        if (sent_dat.size() !== exp_tx.size()) begin
            failures++;
            $display("FAIL %s_count got=%0d exp=%0d", tag,
                     sent_dat.size(), exp_tx.size());
        end
        for (int i = 0; i < sent_dat.size() && i < exp_tx.size(); i++) begin
            checks++;
            if (sent_dat[i] !== exp_tx[i]) begin
                failures++;
                $display("FAIL %s_data[%0d] got=%h exp=%h", tag, i,
                         sent_dat[i], exp_tx[i]);
            end
            checks++;
            if (sent_busy[i] !== 1'b0) begin
                failures++;
                $display("FAIL %s_busy[%0d] got=%b exp=0", tag, i,
                         sent_busy[i]);
            end
            if (i > 0) begin
                checks++;
                if (sent_cyc[i] - sent_cyc[i-1] < 3) begin
                    failures++;
                    $display("FAIL %s_gap[%0d] got=%0d exp>=3", tag, i,
                             sent_cyc[i] - sent_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_reset();
        busy_len = 0;
        busy_hold = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.full_o, bus.empty_o, bus.overflow_o, bus.uart_wr_o}
            !== 4'b0100) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0100",
                     {bus.full_o, bus.empty_o, bus.overflow_o, bus.uart_wr_o});
        end
        checks++;
        if (bus.count_o !== '0) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=0", bus.count_o);
        end
        checks++;
        if (bus.uart_dat_o !== 8'h00) begin
            failures++;
            $display("FAIL reset_dat got=%h exp=00", bus.uart_dat_o);
        end
        rst = 1'b0;
        model_reset();
        cyc(1'b0, 8'h00, 1'b0);
        checks++;
        if (bus.uart_wr_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_nowr got=%b exp=0", bus.uart_wr_o);
        end
    endtask

    task automatic test_single();
        model_reset();
        busy_len = 3;
        cyc(1'b1, 8'hA5, 1'b0);
        checks++;
        if (bus.uart_wr_o !== 1'b0 || bus.count_o !== CW'(1)) begin
            failures++;
            $display("FAIL single_push wr=%b cnt=%0d exp wr=0 cnt=1",
                     bus.uart_wr_o, bus.count_o);
        end
        cyc(1'b0, 8'h00, 1'b0);
        checks++;
        if (bus.uart_wr_o !== 1'b1 || bus.uart_dat_o !== 8'hA5) begin
            failures++;
            $display("FAIL single_pulse wr=%b dat=%h exp wr=1 dat=a5",
                     bus.uart_wr_o, bus.uart_dat_o);
        end
        checks++;
        if (bus.empty_o !== 1'b1) begin
            failures++;
            $display("FAIL single_empty got=%b exp=1", bus.empty_o);
        end
        drain(200);
        exp_tx.delete();
        exp_tx.push_back(8'hA5);
        check_log("single");
        checks++;
        if (bus.uart_dat_o !== 8'hA5) begin
            failures++;
            $display("FAIL single_hold got=%h exp=a5", bus.uart_dat_o);
        end
    endtask

    task automatic test_back_to_back();
        model_reset();
        busy_len = 11;
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(i + 1), 1'b0);
        drain(600);
        exp_tx.delete();
        for (int i = 0; i < 8; i++) exp_tx.push_back(8'(i + 1));
        check_log("b2b");
        checks++;
        if (bus.overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ovf got=%b exp=0", bus.overflow_o);
        end
    endtask

    task automatic test_overflow();
        model_reset();
        busy_len = 5;
        busy_hold = 1'b1;
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 8'($urandom_range(0, 254)), 1'b0);
        cyc(1'b1, 8'hFF, 1'b0);
        checks++;
        if ({bus.full_o, bus.overflow_o} !== 2'b11
            || bus.count_o !== CW'(8)) begin
            failures++;
            $display("FAIL ovf_full full=%b ovf=%b cnt=%0d exp 1 1 8",
                     bus.full_o, bus.overflow_o, bus.count_o);
        end
        repeat (3) cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        checks++;
        if (bus.count_o !== '0 || bus.overflow_o !== 1'b0
            || bus.empty_o !== 1'b1) begin
            failures++;
            $display("FAIL ovf_clr cnt=%0d ovf=%b empty=%b exp 0 0 1",
                     bus.count_o, bus.overflow_o, bus.empty_o);
        end
        busy_hold = 1'b0;
        drain(200);
        checks++;
        if (sent_dat.size() !== 0) begin
            failures++;
            $display("FAIL ovf_nosend got=%0d pulses exp=0",
                     sent_dat.size());
        end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] v[9];
        model_reset();
        busy_len = 4;
        busy_hold = 1'b1;
        foreach (v[i]) v[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) cyc(1'b1, v[i], 1'b0);
        busy_hold = 1'b0;
        cyc(1'b1, v[8], 1'b0);
        checks++;
        if (bus.uart_wr_o !== 1'b1 || bus.count_o !== CW'(8)
            || bus.overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL pp_full wr=%b cnt=%0d ovf=%b exp 1 8 0",
                     bus.uart_wr_o, bus.count_o, bus.overflow_o);
        end
        drain(800);
        exp_tx.delete();
        foreach (v[i]) exp_tx.push_back(v[i]);
        check_log("pp");
    endtask

    task automatic test_timeout();
        logic [7:0] a, b;
        model_reset();
        busy_len = 0;
        a = 8'($urandom);
        b = 8'($urandom);
        cyc(1'b1, a, 1'b0);
        cyc(1'b1, b, 1'b0);
        drain(200);
        exp_tx.delete();
        exp_tx.push_back(a);
        exp_tx.push_back(b);
        check_log("tmo");
        // ISSUE 1 + WAIT_BUSY 4 + IDLE 1 cycles between requests
        checks++;
        if (sent_cyc.size() != 2 || sent_cyc[1] - sent_cyc[0] != 6) begin
            failures++;
            $display("FAIL tmo_gap pulses=%0d gap=%0d exp 2 pulses gap=6",
                     sent_cyc.size(),
                     sent_cyc.size() == 2 ? sent_cyc[1] - sent_cyc[0] : -1);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] n;
        model_reset();
        busy_len = 20;
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'($urandom), 1'b0);
        repeat (2) cyc(1'b0, 8'h00, 1'b0);
        checks++;
        if (bus.count_o !== CW'(3) || busy_cnt == 0) begin
            failures++;
            $display("FAIL rmid_pre cnt=%0d busy=%0d exp cnt=3 busy>0",
                     bus.count_o, busy_cnt);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.full_o, bus.empty_o, bus.overflow_o, bus.uart_wr_o}
            !== 4'b0100 || bus.count_o !== '0
            || bus.uart_dat_o !== 8'h00) begin
            failures++;
            $display("FAIL rmid_async flags=%b cnt=%0d dat=%h exp 0100 0 00",
                     {bus.full_o, bus.empty_o, bus.overflow_o, bus.uart_wr_o},
                     bus.count_o, bus.uart_dat_o);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cyc(1'b0, 8'h00, 1'b0);
        checks++;
        if (bus.uart_wr_o !== 1'b0) begin
            failures++;
            $display("FAIL rmid_first got=%b exp=0", bus.uart_wr_o);
        end
        repeat (30) cyc(1'b0, 8'h00, 1'b0);
        checks++;
        if (sent_dat.size() !== 0) begin
            failures++;
            $display("FAIL rmid_quiet got=%0d pulses exp=0", sent_dat.size());
        end
        n = 8'($urandom);
        cyc(1'b1, n, 1'b0);
        drain(200);
        exp_tx.delete();
        exp_tx.push_back(n);
        check_log("rmid");
    endtask

    task automatic test_random();
        logic [CW+2:0] got, exp;
        model_reset();
        for (int r = 0; r < 6; r++) begin
            busy_len = $urandom_range(0, 12);
            for (int k = 0; k < 100; k++) begin
                cyc(($urandom % 3) != 0, 8'($urandom),
                    ($urandom % 40) == 0);
                got = {bus.count_o, bus.full_o, bus.empty_o, bus.overflow_o};
                exp = {CW'(mq.size()), mq.size() == DEPTH,
                       mq.size() == 0, m_ovf};
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL rnd_state cyc=%0d got=%b exp=%b",
                             cyc_n, got, exp);
                end
            end
        end
        drain(1000);
        check_log("rnd");
    endtask

    initial begin
        rst = 1'b1;
        bus.wr_en_i   = 1'b0;
        bus.wr_data_i = 8'h00;
        bus.clr_i     = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_push_pop_full();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
